// File: rtl/specreg_pkg.sv
// ============================================================================
// Module : specreg_pkg
// Shared command codes, flag indices and saved-context type for the status register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package specreg_pkg;

  localparam logic [3:0] UPD_HOLD     = 4'd0;
  localparam logic [3:0] UPD_BS       = 4'd1;
  localparam logic [3:0] UPD_ALU      = 4'd2;
  localparam logic [3:0] UPD_NZ       = 4'd3;
  localparam logic [3:0] UPD_V        = 4'd4;
  localparam logic [3:0] UPD_SWI      = 4'd5;
  localparam logic [3:0] UPD_RET      = 4'd6;
  localparam logic [3:0] UPD_BIOS_OFF = 4'd7;
  localparam logic [3:0] UPD_WRITE    = 4'd8;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CTX_FLAG_W = 4;
  localparam int CTX_MODE_W = 2;

  typedef struct packed {
    logic [CTX_FLAG_W-1:0] flags;
    logic [CTX_MODE_W-1:0] mode;
  } ctx_t;

endpackage

`default_nettype wire

// File: rtl/context_lifo.sv
// ============================================================================
// Module : context_lifo
// Saturating LIFO of saved contexts; illegal push/pop is dropped and flagged.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module context_lifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_top_idx;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !push && !empty;
  assign overflow  = push && full;
  assign underflow = pop && !push && empty;
  assign w_top_idx = r_count[AW-1:0] - AW'(1);
  assign top_data  = r_mem[w_top_idx];
  assign count     = r_count;

  // Storage is never reset: entries above the count are don't-care.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_count[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_push_ok) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop_ok) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/status_reg_stack.sv
// ============================================================================
// Module : status_reg_stack
// NZCV/mode/BIOS status register with nested exception context stack.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module status_reg_stack
  import specreg_pkg::*;
#(
  parameter int FLAG_W    = 4,
  parameter int MODE_W    = 2,
  parameter int DEPTH     = 4,
  parameter int USER_MODE = 1,
  parameter int EXC_MODE  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [3:0]                 update_mode,
  input  logic                       irq_enter,
  input  logic [3:0]                 alu_flags,
  input  logic [2:0]                 bs_flags,
  input  logic [FLAG_W+MODE_W-1:0]   wr_data,
  output logic [FLAG_W-1:0]          flags,
  output logic [MODE_W-1:0]          mode,
  output logic                       is_bios,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       stack_overflow,
  output logic                       stack_underflow,
  output logic                       priv_fault
);

  logic [FLAG_W-1:0]        r_flags;
  logic [MODE_W-1:0]        r_mode;
  logic                     r_bios;
  logic                     r_ovf;
  logic                     r_unf;
  logic                     r_fault;

  logic [FLAG_W-1:0]        w_flags_nxt;
  logic [MODE_W-1:0]        w_mode_nxt;
  logic                     w_bios_nxt;
  logic                     w_fault_nxt;
  logic                     w_push;
  logic                     w_pop;
  logic [3:0]               w_cmd;
  logic [FLAG_W+MODE_W-1:0] w_top;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_ovf;
  logic                     w_unf;

  context_lifo #(
    .WIDTH (FLAG_W + MODE_W),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data ({r_flags, r_mode}),
    .top_data  (w_top),
    .count     (depth),
    .full      (w_full),
    .empty     (w_empty),
    .overflow  (w_ovf),
    .underflow (w_unf)
  );

  // An interrupt request replaces the whole command, flag updates included.
  assign w_cmd = irq_enter ? UPD_SWI : update_mode;

  always_comb begin
    w_flags_nxt = r_flags;
    w_mode_nxt  = r_mode;
    w_bios_nxt  = r_bios;
    w_fault_nxt = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (enable) begin
      case (w_cmd)
        UPD_BS:   w_flags_nxt[FLAG_N:FLAG_C] = bs_flags;
        UPD_ALU:  w_flags_nxt = alu_flags;
        UPD_NZ:   w_flags_nxt[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
        UPD_V:    w_flags_nxt[FLAG_V] = alu_flags[FLAG_V];
        UPD_SWI: begin
          w_push = 1'b1;
          if (!w_full) w_mode_nxt = MODE_W'(EXC_MODE);
        end
        UPD_RET: begin
          w_pop = 1'b1;
          if (!w_empty) {w_flags_nxt, w_mode_nxt} = w_top;
        end
        UPD_BIOS_OFF: begin
          if (r_bios) begin
            w_bios_nxt = 1'b0;
            w_mode_nxt = MODE_W'(USER_MODE);
          end
        end
        UPD_WRITE: begin
          if (r_mode == '0) {w_flags_nxt, w_mode_nxt} = wr_data;
          else              w_fault_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_flags <= '0;
      r_mode  <= '0;
      r_bios  <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_flags <= w_flags_nxt;
      r_mode  <= w_mode_nxt;
      r_bios  <= w_bios_nxt;
      r_ovf   <= r_ovf | w_ovf;
      r_unf   <= r_unf | w_unf;
      r_fault <= w_fault_nxt;
    end
  end

  assign flags           = enable ? r_flags : {FLAG_W{1'b1}};
  assign mode            = enable ? r_mode  : {MODE_W{1'b1}};
  assign is_bios         = r_bios;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;
  assign priv_fault      = r_fault & enable;

endmodule

`default_nettype wire

// File: tb/tb_status_reg_stack.sv
// ============================================================================
// Module : tb_status_reg_stack
// Self-checking bench: queue-based context model plus directed literal checks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_status_reg_stack;
  import specreg_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] update_mode = 4'd0;
  logic       irq_enter = 1'b0;
  logic [3:0] alu_flags = 4'd0;
  logic [2:0] bs_flags = 3'd0;
  logic [5:0] wr_data = 6'd0;
  logic [3:0] flags;
  logic [1:0] mode;
  logic       is_bios;
  logic [2:0] depth;
  logic       stack_overflow;
  logic       stack_underflow;
  logic       priv_fault;

  status_reg_stack dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .update_mode     (update_mode),
    .irq_enter       (irq_enter),
    .alu_flags       (alu_flags),
    .bs_flags        (bs_flags),
    .wr_data         (wr_data),
    .flags           (flags),
    .mode            (mode),
    .is_bios         (is_bios),
    .depth           (depth),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow),
    .priv_fault      (priv_fault)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  logic [3:0] m_flags;
  logic [1:0] m_mode;
  logic       m_bios, m_ovf, m_unf, m_pf;
  ctx_t       m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: applies one clock's worth of the command rules.
  task automatic model_step();
    logic [3:0] code;
    ctx_t c;
    if (reset) begin
      m_flags = 4'h0; m_mode = 2'd0; m_bios = 1'b1;
      m_ovf = 1'b0; m_unf = 1'b0; m_pf = 1'b0;
      m_stack.delete();
      return;
    end
    m_pf = 1'b0;
    if (!enable) return;
    code = irq_enter ? 4'd5 : update_mode;
    case (code)
      4'd1: m_flags = {bs_flags, m_flags[0]};
      4'd2: m_flags = alu_flags;
      4'd3: m_flags = {alu_flags[3:2], m_flags[1:0]};
      4'd4: m_flags = {m_flags[3:1], alu_flags[0]};
      4'd5: begin
        if (m_stack.size() == 4) m_ovf = 1'b1;
        else begin
          c.flags = m_flags; c.mode = m_mode;
          m_stack.push_back(c);
          m_mode = 2'd0;
        end
      end
      4'd6: begin
        if (m_stack.size() == 0) m_unf = 1'b1;
        else begin
          c = m_stack.pop_back();
          m_flags = c.flags; m_mode = c.mode;
        end
      end
      4'd7: if (m_bios) begin m_bios = 1'b0; m_mode = 2'd1; end
      4'd8: begin
        if (m_mode == 2'd0) {m_flags, m_mode} = wr_data;
        else m_pf = 1'b1;
      end
      default: ;
    endcase
  endtask

  always @(negedge clock) begin
    if (armed) begin
      chk("flags", 32'(flags), enable ? 32'(m_flags) : 32'hF);
      chk("mode", 32'(mode), enable ? 32'(m_mode) : 32'h3);
      chk("is_bios", 32'(is_bios), 32'(m_bios));
      chk("depth", 32'(depth), 32'(m_stack.size()));
      chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
      chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
      chk("priv_fault", 32'(priv_fault), 32'(m_pf & enable));
    end
  end

  task automatic apply(input logic [3:0] um, input logic [3:0] alu = 4'h0,
                       input logic [2:0] bs = 3'h0, input logic irq = 1'b0,
                       input logic en = 1'b1, input logic rst = 1'b0,
                       input logic [5:0] wr = 6'h0);
    update_mode = um; alu_flags = alu; bs_flags = bs;
    irq_enter = irq; enable = en; reset = rst; wr_data = wr;
    @(posedge clock);
    model_step();
    armed = 1'b1;
    #1;
  endtask

  initial begin
    apply(4'd0, 4'h0, 3'h0, 1'b0, 1'b0, 1'b1);
    apply(4'd0, 4'h0, 3'h0, 1'b0, 1'b1, 1'b1);
    chk("rst flags", 32'(flags), 32'h0);
    chk("rst bios", 32'(is_bios), 32'h1);
    chk("rst depth", 32'(depth), 32'h0);

    apply(4'd2, 4'b1010);
    chk("alu flags", 32'(flags), 32'hA);
    chk("alu mode", 32'(mode), 32'h0);
    apply(4'd0, 4'h0, 3'h0, 1'b0, 1'b0);
    chk("dis flags", 32'(flags), 32'hF);
    chk("dis mode", 32'(mode), 32'h3);

    apply(4'd7);
    chk("bios off", 32'(is_bios), 32'h0);
    chk("user mode", 32'(mode), 32'h1);
    apply(4'd8, 4'h0, 3'h0, 1'b0, 1'b1, 1'b0, 6'b111100);
    chk("priv fault", 32'(priv_fault), 32'h1);
    chk("write rejected", 32'(flags), 32'hA);
    apply(4'd7);
    chk("fault one cycle", 32'(priv_fault), 32'h0);

    apply(4'd2, 4'b0110);
    apply(4'd5);
    chk("swi mode", 32'(mode), 32'h0);
    chk("swi depth", 32'(depth), 32'h1);
    apply(4'd2, 4'b1001);
    apply(4'd6);
    chk("ret flags", 32'(flags), 32'h6);
    chk("ret mode", 32'(mode), 32'h1);

    for (int i = 0; i < 5; i++) apply(4'd0, 4'h0, 3'h0, 1'b1);
    chk("irq sat depth", 32'(depth), 32'h4);
    chk("irq overflow", 32'(stack_overflow), 32'h1);
    for (int i = 0; i < 4; i++) apply(4'd6);
    chk("lifo last mode", 32'(mode), 32'h1);
    chk("lifo empty", 32'(depth), 32'h0);
    apply(4'd6);
    chk("underflow", 32'(stack_underflow), 32'h1);

    apply(4'd2, 4'b0011);
    apply(4'd0, 4'h0, 3'h0, 1'b1);
    apply(4'd2, 4'b1100);
    apply(4'd5);
    apply(4'd6);
    chk("nest ret1 flags", 32'(flags), 32'hC);
    apply(4'd6);
    chk("nest ret2 flags", 32'(flags), 32'h3);
    chk("nest ret2 mode", 32'(mode), 32'h1);

    apply(4'd1, 4'h0, 3'b110);
    chk("bs flags", 32'(flags), 32'hD);
    apply(4'd3, 4'b0000);
    apply(4'd4, 4'b0000);
    chk("nz+v flags", 32'(flags), 32'h0);
    apply(4'd0, 4'h0, 3'h0, 1'b1, 1'b0);
    chk("irq ignored", 32'(depth), 32'h0);

    apply(4'd2, 4'b1111, 3'h0, 1'b1);
    chk("irq no merge", 32'(flags), 32'h0);
    apply(4'd6);
    chk("irq ctx flags", 32'(flags), 32'h0);

    for (int i = 0; i < 3; i++) apply(4'd5);
    apply(4'd0, 4'h0, 3'h0, 1'b1, 1'b1, 1'b1);
    chk("reset depth", 32'(depth), 32'h0);
    chk("reset ovf", 32'(stack_overflow), 32'h0);
    chk("reset bios", 32'(is_bios), 32'h1);

    apply(4'd8, 4'h0, 3'h0, 1'b0, 1'b1, 1'b0, 6'b101110);
    chk("priv write flags", 32'(flags), 32'hB);
    chk("priv write mode", 32'(mode), 32'h2);
    apply(4'd8, 4'h0, 3'h0, 1'b0, 1'b1, 1'b0, 6'b000000);
    apply(4'd0);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
